data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum BUSY cycles allowed without mem_ack.
REQ-002 Parameter AW, default 32: address/data width, fixed at 32.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 MemRead  input  1  datapath load request, level, held until Stall is low.
REQ-006 MemWrite  input  1  datapath store request, level, held until Stall is low.
REQ-007 ByteAcc  input  1  1 = byte access (LDRB/STRB), 0 = word access.
REQ-008 ALUResult  input  32  byte address from the datapath ALU.
REQ-009 WriteData  input  32  store data from the register file.
REQ-010 ReadData  output  32  load result to the datapath result mux.
REQ-011 Stall  output  1  freezes PC and register-file write while high.
REQ-012 MemFault  output  1  sticky flag: an access timed out.
REQ-013 mem_req  output  1  memory request, held until ack or timeout.
REQ-014 mem_we  output  1  1 = write, 0 = read.
REQ-015 mem_addr  output  32  word-aligned address.
REQ-016 mem_be  output  4  byte-lane enables.
REQ-017 mem_wdata  output  32  write data.
REQ-018 mem_ack  input  1  memory completion, valid only while mem_req is high.
REQ-019 mem_rdata  input  32  read data, valid in the same cycle as mem_ack.

Function
REQ-020 FSM states SHALL be IDLE, BUSY, DONE.
- IDLE->BUSY when MemRead|MemWrite.
- BUSY->DONE on mem_ack or timeout.
- DONE->IDLE unconditionally.
REQ-021 On the IDLE->BUSY edge, capture into registers: address, WriteData, ByteAcc, and we = MemWrite. When MemRead and MemWrite are both high, the access is a write.
REQ-022 Stall SHALL be combinational: (IDLE & (MemRead|MemWrite)) | BUSY. Stall SHALL be 0 in DONE.
REQ-023 mem_req = BUSY, and SHALL be driven only from registered state.
REQ-024 In BUSY, mem_addr = {addr[31:2],2'b00} and mem_we = captured we.
REQ-025 mem_be for a word access SHALL be 4'b1111; for a byte access, one-hot at bit addr[1:0].
REQ-026 mem_wdata for a word access SHALL be the captured data; for a byte access, data[7:0] replicated four times.
REQ-027 A word access SHALL ignore addr[1:0]; no alignment fault is raised.
REQ-028 A read completing with mem_ack SHALL register ReadData:
- word access: mem_rdata.
- byte access: zero-extended byte at lane addr[1:0].
ReadData is valid in DONE and holds until the next read completes.
REQ-029 A write completing SHALL leave ReadData unchanged.
REQ-030 A BUSY-cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ack. When it reaches TIMEOUT: go to DONE, set ReadData=0 for reads, set MemFault=1.
REQ-031 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success; no fault is raised.
REQ-032 mem_ack while not in BUSY SHALL be ignored.
REQ-033 MemFault SHALL clear only on reset.
REQ-034 Best-case latency, from request seen to Stall low: 2 cycles (IDLE->BUSY, ack in first BUSY cycle, DONE). Each extra ack wait adds 1 cycle.
REQ-035 A request still high in DONE SHALL NOT start a new access. A new access starts only from IDLE in the following cycle.

Reset
REQ-036 While reset=0, all of the following SHALL hold asynchronously: state=IDLE, counter=0, ReadData=0, MemFault=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset asserted during BUSY SHALL drop mem_req immediately and abandon the access; the later mem_ack SHALL be ignored.
REQ-038 After reset release, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-039 Word load: ALUResult=0x104, MemRead=1, ack on 1st BUSY cycle with mem_rdata=0xDEADBEEF -> mem_addr=0x104, mem_be=1111, Stall high 2 cycles, ReadData=0xDEADBEEF in DONE.
REQ-040 Byte store: ALUResult=0x203, WriteData=0x000000A5, MemWrite=1 -> mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-041 Byte load: ALUResult=0x11, mem_rdata=0x12345678 -> ReadData=0x00000056.
REQ-042 Timeout: MemRead with no ack, TIMEOUT=15 -> mem_req high 15 cycles, then DONE, ReadData=0, MemFault=1 sticky.
REQ-043 Conflict plus late ack: MemRead=MemWrite=1 -> mem_we=1. Ack arriving at counter=TIMEOUT -> MemFault stays 0.
REQ-044 Reset mid-BUSY: reset=0 on 2nd BUSY cycle -> mem_req=0 immediately. After release, ack pulse -> no state change, Stall=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: turns datapath load/store requests into a
// req/ack memory handshake, stalls the pipeline while the access is in flight,
// and raises a sticky fault if the memory never answers.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned AW      = 32  // lane/replication logic assumes 32
) (
  input  logic          clk,
  input  logic          reset,      // active-low, asynchronous
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic          ByteAcc,
  input  logic [AW-1:0] ALUResult,
  input  logic [AW-1:0] WriteData,
  output logic [AW-1:0] ReadData,
  output logic          Stall,
  output logic          MemFault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [AW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // The counter never holds TIMEOUT itself: the cycle that would reach it
  // leaves BUSY instead, so it only needs to cover 0..TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   wdata_q, wdata_d;
  logic            byte_q, byte_d;
  logic            we_q, we_d;
  logic [AW-1:0]   rdata_q, rdata_d;
  logic            fault_q, fault_d;

  logic            busy;
  logic            req_any;
  logic [1:0]      lane;
  logic [7:0]      rbyte;
  logic [AW-1:0]   load_data;

  assign busy    = (state_q == StBusy);
  assign req_any = MemRead | MemWrite;
  assign lane    = addr_q[1:0];

  // Select the load result: full word, or the addressed byte zero-extended.
  always_comb begin
    rbyte     = mem_rdata[{lane, 3'b000} +: 8];
    load_data = byte_q ? {{(AW-8){1'b0}}, rbyte} : mem_rdata;
  end

  // Next-state logic: request capture in IDLE, ack/timeout resolution in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    byte_d  = byte_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    fault_d = fault_q;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          state_d = StBusy;
          cnt_d   = '0;
          addr_d  = ALUResult;
          wdata_d = WriteData;
          byte_d  = ByteAcc;
          // Store wins when both requests are raised together.
          we_d    = MemWrite;
        end
      end
      StBusy: begin
        // Ack takes priority, so an ack on the final allowed cycle succeeds.
        if (mem_ack) begin
          state_d = StDone;
          if (!we_q) begin
            rdata_d = load_data;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StDone;
          fault_d = 1'b1;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Single-cycle release; a request still held here is not restarted.
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State and captured-request registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      byte_q  <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      byte_q  <= byte_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Memory-side outputs come only from registers and are zero outside BUSY,
  // so reset immediately silences the bus.
  always_comb begin
    mem_req   = busy;
    mem_we    = busy & we_q;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    if (busy) begin
      mem_addr  = {addr_q[AW-1:2], 2'b00};
      mem_be    = byte_q ? (4'b0001 << lane) : 4'b1111;
      mem_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    end
  end

  // Datapath-side outputs; Stall rises in the same cycle the request appears.
  always_comb begin
    Stall    = ((state_q == StIdle) & req_any) | busy;
    ReadData = rdata_q;
    MemFault = fault_q;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus randomized
// accesses compared against a transaction-level model of the controller.
module tb_data_mem_ctrl;

  localparam int unsigned TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        MemRead, MemWrite, ByteAcc;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MemFault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: last completed load result and sticky fault.
  logic [31:0] rd_model;
  logic        fault_model;

  data_mem_ctrl #(
    .TIMEOUT(TIMEOUT),
    .AW     (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ByteAcc  (ByteAcc),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .MemFault (MemFault),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // One complete access. ack_at is the 0-based BUSY cycle carrying mem_ack
  // (negative = never). hold keeps the request raised through DONE.
  task automatic do_access(input logic rd, input logic wr, input logic bacc,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdat,
                           input bit hold);
    int          cyc;
    int          exp_cyc;
    bit          success;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    int          ln;

    ln        = int'(addr % 4);
    exp_addr  = addr - (addr % 4);
    exp_be    = bacc ? 4'(1 << ln) : 4'hF;
    exp_wdata = bacc ? (32'(wd[7:0]) * 32'h0101_0101) : wd;
    success   = (ack_at >= 0) && (ack_at < int'(TIMEOUT));
    exp_cyc   = success ? ack_at + 1 : int'(TIMEOUT);

    @(negedge clk);
    MemRead = rd; MemWrite = wr; ByteAcc = bacc; ALUResult = addr; WriteData = wd;
    mem_ack = 1'b0;
    #1;
    n_cmp++;
    if (Stall !== 1'b1) begin
      n_err++; $display("FAIL stall_on_request: got %b, required 1", Stall);
    end

    @(negedge clk);
    cyc = 0;
    while (mem_req === 1'b1 && cyc < 64) begin
      if (cyc == 0) begin
        n_cmp++;
        if (mem_addr !== exp_addr) begin
          n_err++; $display("FAIL mem_addr: got %h, required %h", mem_addr, exp_addr);
        end
        n_cmp++;
        if (mem_be !== exp_be) begin
          n_err++; $display("FAIL mem_be: got %b, required %b", mem_be, exp_be);
        end
        n_cmp++;
        if (mem_we !== wr) begin
          n_err++; $display("FAIL mem_we: got %b, required %b", mem_we, wr);
        end
        if (wr) begin
          n_cmp++;
          if (mem_wdata !== exp_wdata) begin
            n_err++; $display("FAIL mem_wdata: got %h, required %h", mem_wdata, exp_wdata);
          end
        end
      end
      n_cmp++;
      if (Stall !== 1'b1) begin
        n_err++; $display("FAIL stall_busy: cycle %0d got %b, required 1", cyc, Stall);
      end
      if (cyc == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rdat;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      cyc++;
      @(negedge clk);
    end
    mem_ack = 1'b0;

    // Model update for the completed transaction.
    if (!wr) begin
      if (success) rd_model = bacc ? ((rdat >> (8 * ln)) & 32'hFF) : rdat;
      else         rd_model = 32'h0;
    end
    if (!success) fault_model = 1'b1;

    n_cmp++;
    if (cyc !== exp_cyc) begin
      n_err++; $display("FAIL busy_cycles: got %0d, required %0d", cyc, exp_cyc);
    end
    n_cmp++;
    if (Stall !== 1'b0) begin
      n_err++; $display("FAIL stall_done: got %b, required 0", Stall);
    end
    n_cmp++;
    if (ReadData !== rd_model) begin
      n_err++; $display("FAIL read_data: got %h, required %h", ReadData, rd_model);
    end
    n_cmp++;
    if (MemFault !== fault_model) begin
      n_err++; $display("FAIL mem_fault: got %b, required %b", MemFault, fault_model);
    end

    if (hold) begin
      // Request still up in DONE: next cycle must be IDLE, not a new access.
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || Stall !== 1'b1) begin
        n_err++;
        $display("FAIL no_restart_from_done: got req=%b stall=%b, required req=0 stall=1",
                 mem_req, Stall);
      end
      MemRead = 1'b0; MemWrite = 1'b0;
    end else begin
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || Stall !== 1'b0) begin
        n_err++;
        $display("FAIL back_to_idle: got req=%b stall=%b, required 0 0", mem_req, Stall);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; ByteAcc = 1'b0;
    ALUResult = '0; WriteData = '0; mem_ack = 1'b0; mem_rdata = '0;
    rd_model = '0; fault_model = 1'b0;
    #12;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, MemFault, Stall} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ctrl: got req=%b we=%b be=%b fault=%b stall=%b, required all 0",
               mem_req, mem_we, mem_be, MemFault, Stall);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, ReadData} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0",
               mem_addr, mem_wdata, ReadData);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    do_access(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    do_access(1'b0, 1'b1, 1'b1, 32'h203, 32'h0000_00A5, 0, 32'h0, 1'b0);
    do_access(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 2, 32'h1234_5678, 1'b0);
    // Word access with misaligned address: low bits dropped, no fault.
    do_access(1'b1, 1'b0, 1'b0, 32'h0000_1237, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
  endtask

  task automatic test_conflict_late_ack();
    do_access(1'b1, 1'b1, 1'b0, 32'h400, 32'h5555_AAAA, int'(TIMEOUT) - 1,
              32'h0BAD_0BAD, 1'b0);
  endtask

  task automatic test_idle_ack();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = $urandom;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || Stall !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ack_state: got req=%b stall=%b, required 0 0", mem_req, Stall);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      n_cmp++;
      if (ReadData !== rd_model) begin
        n_err++; $display("FAIL idle_ack_rdata: got %h, required %h", ReadData, rd_model);
      end
    end
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, -1, 32'h0, 1'b0);
    // Fault must stay set across a following successful access.
    do_access(1'b1, 1'b0, 1'b0, 32'h804, 32'h0, 0, 32'h1111_2222, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic rd, wr, bacc;
      int   ack_at;
      int   sel;
      sel  = int'($urandom_range(0, 2));
      rd   = (sel != 1);
      wr   = (sel != 0);
      bacc = 1'($urandom_range(0, 1));
      ack_at = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      do_access(rd, wr, bacc, $urandom, $urandom, ack_at, $urandom,
                bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    MemRead = 1'b1; ByteAcc = 1'b0; ALUResult = 32'h0000_0C00;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_err++; $display("FAIL busy_before_reset: got %b, required 1", mem_req);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_be} !== 6'h00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_busy: got req=%b be=%b addr=%h, required all 0",
               mem_req, mem_be, mem_addr);
    end
    MemRead = 1'b0;
    rd_model = '0; fault_model = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
    #1;
    n_cmp++;
    if (Stall !== 1'b0 || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL late_ack_state: got stall=%b req=%b, required 0 0", Stall, mem_req);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    n_cmp++;
    if (ReadData !== rd_model || MemFault !== fault_model) begin
      n_err++;
      $display("FAIL late_ack_regs: got rdata=%h fault=%b, required %h %b",
               ReadData, MemFault, rd_model, fault_model);
    end
    // Controller must be fully usable after the abandoned access.
    do_access(1'b1, 1'b0, 1'b1, 32'h0000_0C02, 32'h0, 0, 32'hA1B2_C3D4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_conflict_late_ack();
    test_idle_ack();
    test_timeout();
    test_random();
    test_idle_ack();
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
